// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB requester bridging a valid/ready command stream to APB transfers
//
// Purpose:
//   Accepts one command at a time (addr, write, wdata, wait) and runs it as an
//   APB SETUP/ACCESS transfer. PREADY wait states are honoured. An ACCESS phase
//   that stays not-ready for TIMEOUT_CYC cycles is aborted with an error
//   response. TIMEOUT_CYC=0 disables the timeout. Each completed or aborted
//   transfer returns one response (rdata, err) on a valid/ready port.
//
// Ports:
//   PCLK, PRESET          clock (rising edge) and synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_wait
//   rsp_valid/rsp_ready   response handshake; rsp_rdata, rsp_err
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT    APB request outputs (registered)
//   PREADY, PRDATA        APB completion inputs from the slave

module apb_master_bridge #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [WAIT_W-1:0] cmd_wait,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [WAIT_W-1:0] PWAIT,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    // The counter only ever needs to reach TIMEOUT_CYC-1.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [WAIT_W-1:0] pwait_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              timeout_hit;
    logic              cmd_fire;
    logic              rsp_fire;

    // A new command may be taken while the previous response is being consumed
    // on the same edge; otherwise the single response slot would be overwritten.
    assign cmd_ready = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid_q && rsp_ready;

    always_comb begin
        timeout_hit = 1'b0;
        cnt_d       = cnt_q;
        if (TO_EN) begin
            timeout_hit = (cnt_q == CNT_LAST);
            cnt_d       = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwait_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (rsp_fire) begin
                rsp_valid_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        state_q   <= ST_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        // Reads drive zero on PWDATA rather than stale bus data.
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        pwait_q   <= cmd_wait;
                        cnt_q     <= '0;
                    end
                end

                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                    end else if (timeout_hit) begin
                        // Slave never answered: release the bus and report an abort.
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWAIT     = pwait_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
